led_pipe_stage: RTL and testbench

//  - Registered, parametrised successor of the LED colour pipe bus: per-LED stage in the colour pipeline.
//  - Selects per word between upstream colour (i_data) and local override colour (d_data) on `enable`.
//  - Forwards the selected word downstream through a valid/ready interface with a 2-entry skid buffer.
//  - Full throughput, no bubbles; sits between the frame sequencer and the WS2812B bit serialiser.

---
 rtl/led_pipe_pkg.sv | 21 ++
 rtl/led_pipe_scale.sv | 26 ++
 rtl/led_pipe_stage.sv | 159 +++++++++++++++
 tb/tb_led_pipe_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pipe_pkg.sv
// Shared definitions for the LED colour pipe stage: channel indices,
// skid-buffer state encoding and brightness width.
package led_pipe_pkg;

   // Channel positions inside a packed colour word (ch0 in the LSBs)
   localparam int CH_GREEN = 0;
   localparam int CH_RED   = 1;
   localparam int CH_BLUE  = 2;
   localparam int CH_WHITE = 3;

   // Width of the optional global brightness input
   localparam int BRI_W = 8;

   // Occupancy of the main + skid register pair
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

endpackage : led_pipe_pkg

// File: rtl/led_pipe_scale.sv
// Combinational per-channel brightness scaler.
// Result is (ch * (bri + 1)) >> 8, so bri = 255 is an exact identity
// and bri = 0 collapses any channel of 8 bits or fewer to zero.
module led_pipe_scale
   import led_pipe_pkg::*;
#(
   parameter int CH_WIDTH = 8
) (
   input  logic [CH_WIDTH-1:0] ch,
   input  logic [BRI_W-1:0]    bri,
   output logic [CH_WIDTH-1:0] scaled
);

   localparam int PW = CH_WIDTH + BRI_W + 1;

   logic [BRI_W:0] gain_s;
   logic [PW-1:0]  prod_s;

   // Multiply by brightness+1 and drop the fractional byte
   always_comb begin
      gain_s = {1'b0, bri} + {{BRI_W{1'b0}}, 1'b1};
      prod_s = PW'(ch) * PW'(gain_s);
      scaled = CH_WIDTH'(prod_s >> BRI_W);
   end

endmodule : led_pipe_scale

// File: rtl/led_pipe_stage.sv
// Per-LED colour pipeline stage.
// Picks upstream (i_data) or local override (d_data) colour on accept and
// forwards it through a valid/ready interface backed by a 2-entry skid
// buffer, giving full throughput with registered i_ready.
// Optional feature: define LED_PIPE_BRIGHTNESS_EN to add the i_brightness
// port and scale every channel before it is stored.
module led_pipe_stage
   import led_pipe_pkg::*;
#(
   parameter int CH_COUNT = 3,
   parameter int CH_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         i_valid,
   output logic                         i_ready,
   input  logic [CH_COUNT*CH_WIDTH-1:0] i_data,
   input  logic [CH_COUNT*CH_WIDTH-1:0] d_data,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [CH_COUNT*CH_WIDTH-1:0] o_data,
   output logic                         o_src
`ifdef LED_PIPE_BRIGHTNESS_EN
   ,
   input  logic [BRI_W-1:0]             i_brightness
`endif
);

   localparam int DW = CH_COUNT * CH_WIDTH;

   skid_state_t   state_r;
   skid_state_t   state_nxt_s;
   logic          i_ready_r;
   logic          o_valid_r;
   logic [DW-1:0] main_data_r;
   logic          main_src_r;
   logic [DW-1:0] skid_data_r;
   logic          skid_src_r;

   logic          accept_s;
   logic          pop_s;
   logic          load_main_s;
   logic          load_skid_s;
   logic          skid_to_main_s;
   logic [DW-1:0] sel_word_s;
   logic [DW-1:0] word_s;

   assign accept_s   = i_valid & i_ready_r;
   assign pop_s      = o_valid_r & o_ready;
   assign sel_word_s = enable ? d_data : i_data;

`ifdef LED_PIPE_BRIGHTNESS_EN
   for (genvar c = 0; c < CH_COUNT; c++) begin : g_scale
      led_pipe_scale #(
         .CH_WIDTH (CH_WIDTH)
      ) u_scale (
         .ch     (sel_word_s[c*CH_WIDTH +: CH_WIDTH]),
         .bri    (i_brightness),
         .scaled (word_s[c*CH_WIDTH +: CH_WIDTH])
      );
   end
`else
   assign word_s = sel_word_s;
`endif

   // Next occupancy and which register loads on this edge
   always_comb begin
      state_nxt_s    = state_r;
      load_main_s    = 1'b0;
      load_skid_s    = 1'b0;
      skid_to_main_s = 1'b0;
      case (state_r)
         EMPTY: begin
            if (accept_s) begin
               state_nxt_s = ONE;
               load_main_s = 1'b1;
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         ONE: begin
            if (accept_s && !pop_s) begin
               state_nxt_s = FULL;
               load_skid_s = 1'b1;
            end else if (!accept_s && pop_s) begin
               state_nxt_s = EMPTY;
            end else if (accept_s && pop_s) begin
               state_nxt_s = ONE;
               load_main_s = 1'b1;
            end else begin
               state_nxt_s = ONE;
            end
         end
         FULL: begin
            // i_ready is low here, so only a pop can change anything
            if (pop_s) begin
               state_nxt_s    = ONE;
               skid_to_main_s = 1'b1;
            end else begin
               state_nxt_s = FULL;
            end
         end
         default: begin
            state_nxt_s = EMPTY;
         end
      endcase
   end

   // State plus handshake outputs registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= EMPTY;
         i_ready_r <= 1'b1;
         o_valid_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         i_ready_r <= (state_nxt_s != FULL);
         o_valid_r <= (state_nxt_s != EMPTY);
      end
   end

   // Main register: new word, or skid word promoted after a pop from FULL
   always_ff @(posedge clk) begin
      if (rst) begin
         main_data_r <= '0;
         main_src_r  <= 1'b0;
      end else if (load_main_s) begin
         main_data_r <= word_s;
         main_src_r  <= enable;
      end else if (skid_to_main_s) begin
         main_data_r <= skid_data_r;
         main_src_r  <= skid_src_r;
      end else begin
         main_data_r <= main_data_r;
         main_src_r  <= main_src_r;
      end
   end

   // Skid register: catches the word accepted while main is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_data_r <= '0;
         skid_src_r  <= 1'b0;
      end else if (load_skid_s) begin
         skid_data_r <= word_s;
         skid_src_r  <= enable;
      end else begin
         skid_data_r <= skid_data_r;
         skid_src_r  <= skid_src_r;
      end
   end

   assign i_ready = i_ready_r;
   assign o_valid = o_valid_r;
   assign o_data  = main_data_r;
   assign o_src   = main_src_r;

endmodule : led_pipe_stage

// File: tb/tb_led_pipe_stage.sv
// Directed self-checking bench for led_pipe_stage.
// With LED_PIPE_BRIGHTNESS_EN defined it builds a 4-channel stage and
// also checks the brightness scaler; otherwise it uses the 3-channel default.
module tb_led_pipe_stage;

`ifdef LED_PIPE_BRIGHTNESS_EN
   localparam int CH_COUNT = 4;
`else
   localparam int CH_COUNT = 3;
`endif
   localparam int CH_WIDTH = 8;
   localparam int DW       = CH_COUNT * CH_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          i_valid;
   logic          i_ready;
   logic [DW-1:0] i_data;
   logic [DW-1:0] d_data;
   logic          o_valid;
   logic          o_ready;
   logic [DW-1:0] o_data;
   logic          o_src;
`ifdef LED_PIPE_BRIGHTNESS_EN
   logic [7:0]    i_brightness;
`endif

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   led_pipe_stage #(
      .CH_COUNT (CH_COUNT),
      .CH_WIDTH (CH_WIDTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_data  (i_data),
      .d_data  (d_data),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_src   (o_src)
`ifdef LED_PIPE_BRIGHTNESS_EN
      ,
      .i_brightness (i_brightness)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      i_valid = 1'b1;
      i_data  = DW'(24'h123456);
      d_data  = DW'(24'h654321);
      o_ready = 1'b1;
`ifdef LED_PIPE_BRIGHTNESS_EN
      i_brightness = 8'd255;
`endif

      // Reset held two cycles with i_valid high
      tick();
      tick();
      rst     = 1'b0;
      i_valid = 1'b0;
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_o_data",  64'(o_data),  64'd0);
      check("rst_o_src",   64'(o_src),   64'd0);
      check("rst_i_ready", 64'(i_ready), 64'd1);
      tick();
      tick();
      check("rst_no_word", 64'(o_valid), 64'd0);

      // Source select with o_ready high
      i_valid = 1'b1;
      i_data  = DW'(24'h112233);
      d_data  = DW'(24'hAABBCC);
      enable  = 1'b0;
      tick();
      check("sel0_valid", 64'(o_valid), 64'd1);
      check("sel0_data",  64'(o_data),  64'h112233);
      check("sel0_src",   64'(o_src),   64'd0);
      enable = 1'b1;
      tick();
      check("sel1_valid", 64'(o_valid), 64'd1);
      check("sel1_data",  64'(o_data),  64'hAABBCC);
      check("sel1_src",   64'(o_src),   64'd1);
      i_valid = 1'b0;
      enable  = 1'b0;
      tick();
      check("sel_drain", 64'(o_valid), 64'd0);

      // Backpressure: three words offered against a stalled sink
      o_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = DW'(24'h010101);
      tick();
      check("bp_w1_ready", 64'(i_ready), 64'd1);
      check("bp_w1_data",  64'(o_data),  64'h010101);
      i_data = DW'(24'h020202);
      enable = 1'b1;
      d_data = DW'(24'h0A0A0A);
      tick();
      check("bp_full_ready", 64'(i_ready), 64'd0);
      check("bp_full_valid", 64'(o_valid), 64'd1);
      check("bp_full_data",  64'(o_data),  64'h010101);
      check("bp_full_src",   64'(o_src),   64'd0);
      // Changing enable and data while stalled must not disturb stored words
      enable = 1'b0;
      i_data = DW'(24'h030303);
      tick();
      check("bp_hold_ready", 64'(i_ready), 64'd0);
      check("bp_hold_data",  64'(o_data),  64'h010101);
      o_ready = 1'b1;
      tick();
      check("bp_w2_data",  64'(o_data),  64'h0A0A0A);
      check("bp_w2_src",   64'(o_src),   64'd1);
      check("bp_w2_ready", 64'(i_ready), 64'd1);
      tick();
      check("bp_w3_valid", 64'(o_valid), 64'd1);
      check("bp_w3_data",  64'(o_data),  64'h030303);
      i_valid = 1'b0;
      tick();
      check("bp_drain", 64'(o_valid), 64'd0);

      // Throughput: 16 back-to-back words
      i_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         i_data = DW'(24'h100000 + 24'(k));
         tick();
         check("tp_valid", 64'(o_valid), 64'd1);
         check("tp_data",  64'(o_data),  64'h100000 + 64'(k));
         check("tp_ready", 64'(i_ready), 64'd1);
      end
      i_valid = 1'b0;
      tick();
      check("tp_drain", 64'(o_valid), 64'd0);

      // Reset while FULL discards both stored words
      o_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = DW'(24'h0F0F0F);
      tick();
      i_data = DW'(24'h1E1E1E);
      tick();
      check("mr_full_ready", 64'(i_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      i_valid = 1'b0;
      check("mr_o_valid", 64'(o_valid), 64'd0);
      check("mr_i_ready", 64'(i_ready), 64'd1);
      check("mr_o_data",  64'(o_data),  64'd0);
      o_ready = 1'b1;
      tick();
      check("mr_no_word1", 64'(o_valid), 64'd0);
      tick();
      check("mr_no_word2", 64'(o_valid), 64'd0);

`ifdef LED_PIPE_BRIGHTNESS_EN
      // Brightness scaling on both sources
      i_valid      = 1'b1;
      enable       = 1'b0;
      i_data       = 32'hFF804000;
      i_brightness = 8'd127;
      tick();
      check("bri127_data", 64'(o_data), 64'h7F402000);
      i_brightness = 8'd255;
      tick();
      check("bri255_data", 64'(o_data), 64'hFF804000);
      enable       = 1'b1;
      d_data       = 32'h80808080;
      i_brightness = 8'd127;
      tick();
      check("bri_d_data", 64'(o_data), 64'h40404040);
      i_brightness = 8'd0;
      tick();
      check("bri0_data", 64'(o_data), 64'h00000000);
      i_valid = 1'b0;
      tick();
      check("bri_drain", 64'(o_valid), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_led_pipe_stage
